// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and a selectable first-word-fall-through read mode.
module fifo_sync_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 3,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [ADDR_W:0]   count,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              fifo_overflow,
   output logic              fifo_underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              wr_ok;
   logic              rd_ok;

   // A write into a full FIFO is still taken when a read frees the head slot.
   assign wr_ok = write & (~fifo_full | read);
   assign rd_ok = read & ~fifo_empty;

   assign count          = count_q;
   assign fifo_full      = (count_q == DEPTH_C);
   assign fifo_empty     = (count_q == '0);
   assign almost_full    = (count_q >= AF_C);
   assign almost_empty   = (count_q <= AE_C);
   assign fifo_overflow  = overflow_q;
   assign fifo_underflow = underflow_q;

   always_ff @(posedge clk) begin
      if (rst && wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         if (wr_ok && !rd_ok) begin
            count_q <= count_q + (ADDR_W + 1)'(1);
         end else if (rd_ok && !wr_ok) begin
            count_q <= count_q - (ADDR_W + 1)'(1);
         end
         overflow_q  <= write & ~wr_ok;
         underflow_q <= read & ~rd_ok;
      end
   end

   // FWFT shows the head word directly; standard mode registers it on a pop.
   if (FWFT != 0) begin : g_fwft
      assign data_out  = mem[rd_ptr];
      assign valid_out = ~fifo_empty;
   end else begin : g_std
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
         if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
               data_q <= mem[rd_ptr];
            end
         end
      end

      assign data_out  = data_q;
      assign valid_out = valid_q;
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: a standard and an FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_sync_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] d0, d1;
   logic       v0, v1;
   logic [3:0] c0, c1;
   logic       f0, f1, e0, e1, af0, af1, ae0, ae1, o0, o1, u0, u1;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] q[$];
   logic [7:0] m_dout  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ovf   = 1'b0;
   logic       m_unf   = 1'b0;

   typedef struct {
      logic       rst_n;
      logic       wr;
      logic       rd;
      logic [7:0] din;
      int         cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       unf;
      logic [7:0] dout;
      logic       valid;
   } vec_t;

   vec_t vecs[$];

   fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
      .data_out(d0), .valid_out(v0), .count(c0), .fifo_full(f0), .fifo_empty(e0),
      .almost_full(af0), .almost_empty(ae0), .fifo_overflow(o0), .fifo_underflow(u0)
   );

   fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
      .data_out(d1), .valid_out(v1), .count(c1), .fifo_full(f1), .fifo_empty(e1),
      .almost_full(af1), .almost_empty(ae1), .fifo_overflow(o1), .fifo_underflow(u1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue, with the standard-mode output register alongside.
   task automatic modelStep();
      bit full, empty, wr_ok, rd_ok;
      if (!rst) begin
         q.delete();
         m_dout  = 8'h00;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else begin
         full  = (q.size() == 8);
         empty = (q.size() == 0);
         wr_ok = write && (!full || read);
         rd_ok = read && !empty;
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(data_in);
         m_valid = rd_ok;
         m_ovf   = write && !wr_ok;
         m_unf   = read && !rd_ok;
      end
   endtask

   task automatic checkOutput();
      int n;
      n = q.size();
      check("std_count", 32'(c0), 32'(n));
      check("std_full", 32'(f0), 32'(n == 8));
      check("std_empty", 32'(e0), 32'(n == 0));
      check("std_afull", 32'(af0), 32'(n >= 6));
      check("std_aempty", 32'(ae0), 32'(n <= 2));
      check("std_ovf", 32'(o0), 32'(m_ovf));
      check("std_unf", 32'(u0), 32'(m_unf));
      check("std_dout", 32'(d0), 32'(m_dout));
      check("std_valid", 32'(v0), 32'(m_valid));
      check("fwft_count", 32'(c1), 32'(n));
      check("fwft_full", 32'(f1), 32'(n == 8));
      check("fwft_empty", 32'(e1), 32'(n == 0));
      check("fwft_ovf", 32'(o1), 32'(m_ovf));
      check("fwft_unf", 32'(u1), 32'(m_unf));
      check("fwft_valid", 32'(v1), 32'(n != 0));
      if (n != 0) check("fwft_dout", 32'(d1), 32'(q[0]));
   endtask

   task automatic applyStimulus(input logic r_n, input logic w, input logic rd, input logic [7:0] d);
      @(negedge clk);
      rst     = r_n;
      write   = w;
      read    = rd;
      data_in = d;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic addVec(input logic r_n, input logic w, input logic rd, input logic [7:0] d,
                         input int cnt, input logic full, input logic empty, input logic af,
                         input logic ae, input logic ovf, input logic unf,
                         input logic [7:0] dout, input logic valid);
      vec_t v;
      v.rst_n = r_n; v.wr = w; v.rd = rd; v.din = d;
      v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
      v.ovf = ovf; v.unf = unf; v.dout = dout; v.valid = valid;
      vecs.push_back(v);
   endtask

   initial begin
      // reset held with both strobes high
      addVec(0, 1, 1, 8'h55, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0);
      addVec(0, 1, 1, 8'h55, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0);
      for (int i = 1; i <= 8; i++)
         addVec(1, 1, 0, 8'(8'h10 + i - 1), i, i == 8, 0, i >= 6, i <= 2, 0, 0, 8'h00, 0);
      addVec(1, 1, 0, 8'hFF, 8, 1, 0, 1, 0, 1, 0, 8'h00, 0);
      addVec(1, 0, 0, 8'h00, 8, 1, 0, 1, 0, 0, 0, 8'h00, 0);
      for (int j = 1; j <= 8; j++)
         addVec(1, 0, 1, 8'h00, 8 - j, 0, j == 8, (8 - j) >= 6, (8 - j) <= 2, 0, 0,
                8'(8'h10 + j - 1), 1);
      addVec(1, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h17, 0);
      addVec(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h17, 0);
      addVec(1, 1, 1, 8'h30, 1, 0, 0, 0, 1, 0, 1, 8'h17, 0);
      addVec(1, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h30, 1);

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst_n, vecs[k].wr, vecs[k].rd, vecs[k].din);
         check("vec_count", 32'(c0), 32'(vecs[k].cnt));
         check("vec_full", 32'(f0), 32'(vecs[k].full));
         check("vec_empty", 32'(e0), 32'(vecs[k].empty));
         check("vec_afull", 32'(af0), 32'(vecs[k].af));
         check("vec_aempty", 32'(ae0), 32'(vecs[k].ae));
         check("vec_ovf", 32'(o0), 32'(vecs[k].ovf));
         check("vec_unf", 32'(u0), 32'(vecs[k].unf));
         check("vec_dout", 32'(d0), 32'(vecs[k].dout));
         check("vec_valid", 32'(v0), 32'(vecs[k].valid));
      end

      // pointer wrap with interleaved write/read
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 1, 0, 8'(8'h20 + i));
         applyStimulus(1, 0, 1, 8'h00);
         check("wrap_dout", 32'(d0), 32'(8'h20 + i));
      end

      // simultaneous read+write while full
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 8'(8'h40 + i));
      applyStimulus(1, 1, 1, 8'h99);
      check("passthru_count", 32'(c0), 32'd8);
      check("passthru_ovf", 32'(o0), 32'd0);
      check("passthru_dout", 32'(d0), 32'h40);
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 8'h00);
      check("passthru_last", 32'(d0), 32'h99);

      // FWFT fall-through of a single word
      applyStimulus(1, 1, 0, 8'hA5);
      check("fwft_a5_dout", 32'(d1), 32'hA5);
      check("fwft_a5_valid", 32'(v1), 32'd1);
      applyStimulus(1, 0, 1, 8'h00);
      check("fwft_pop_empty", 32'(e1), 32'd1);
      check("fwft_pop_valid", 32'(v1), 32'd0);

      // mid-stream reset discards held words
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 8'(8'h51 + i));
      applyStimulus(0, 0, 0, 8'h00);
      check("midrst_count", 32'(c0), 32'd0);
      applyStimulus(1, 1, 0, 8'h61);
      applyStimulus(1, 1, 0, 8'h62);
      check("midrst_head", 32'(d1), 32'h61);
      applyStimulus(1, 0, 1, 8'h00);
      check("midrst_pop1", 32'(d0), 32'h61);
      applyStimulus(1, 0, 1, 8'h00);
      check("midrst_pop2", 32'(d0), 32'h62);

      // randomized traffic with shifting write/read bias and rare resets
      for (int blk = 0; blk < 8; blk++) begin
         int wp, rp;
         wp = (blk % 2 == 0) ? 75 : 30;
         rp = (blk % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom_range(0, 79) != 0,
                          $urandom_range(0, 99) < wp,
                          $urandom_range(0, 99) < rp,
                          8'($urandom_range(0, 255)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
